fp_expander: RTL and testbench

- Decoder companion to the linear-to-float compressor: converts an 8-bit float code {sign, 3-bit exponent, 4-bit significand} back to a 12-bit two's-complement linear value.
- Shifts the significand left by the exponent, one position per clock, then applies the sign.
- Valid/ready on both sides; sits downstream of the compressor in the loopback/verification path.

---
 rtl/fp_expander.sv | 106 ++++++++++
 tb/tb_fp_expander.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fp_expander.sv
// fp_expander: decodes an 8-bit float code {sign, exponent, significand}
// into an OUT_W-bit two's-complement linear value. The significand is
// shifted left by the exponent one position per clock, then the sign is
// applied. Valid/ready handshake on both the input and the output side.
//
// Optional build macro FP_EXPAND_MIDPOINT_EN: when defined and exp > 0,
// the magnitude is reconstructed at the midpoint of its quantization
// interval (acc | (1 << (exp-1))). When undefined, reconstruction is the
// plain truncating value sig << exp.
module fp_expander #(
    parameter int EXP_W = 3,
    parameter int SIG_W = 4,
    parameter int OUT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [SIG_W-1:0] in_sig,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state;
    logic [OUT_W-2:0] acc;
    logic [EXP_W-1:0] cnt;
    logic             sign;
    logic [OUT_W-1:0] mag;

`ifdef FP_EXPAND_MIDPOINT_EN
    logic [EXP_W-1:0] exp_r;
`endif

    // Input side is open only in IDLE and never while reset is asserted.
    assign in_ready = (state == IDLE) && !rst;
    assign busy     = (state != IDLE);

    // Final unsigned magnitude presented to the sign stage.
    always_comb begin
        mag = {1'b0, acc};
`ifdef FP_EXPAND_MIDPOINT_EN
        if (exp_r != '0) begin
            mag = mag | (OUT_W'(1) << (exp_r - EXP_W'(1)));
        end
`endif
    end

    // Control FSM: load code, shift once per cycle, hold result until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            sign      <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
`ifdef FP_EXPAND_MIDPOINT_EN
            exp_r     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc   <= (OUT_W-1)'(in_sig);
                        cnt   <= in_exp;
                        sign  <= in_sign;
`ifdef FP_EXPAND_MIDPOINT_EN
                        exp_r <= in_exp;
`endif
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        acc <= acc << 1;
                        cnt <= cnt - EXP_W'(1);
                    end else begin
                        out_data  <= sign ? (~mag + OUT_W'(1)) : mag;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_expander.sv
// tb_fp_expander: directed and randomized checks of fp_expander against a
// plain arithmetic reference of the float-code decoding rules.
module tb_fp_expander;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [2:0]  in_exp;
    logic [3:0]  in_sig;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_data;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    fp_expander #(
        .EXP_W(3),
        .SIG_W(4),
        .OUT_W(12)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sign  (in_sign),
        .in_exp   (in_exp),
        .in_sig   (in_sig),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Reference: signed value of the code, reduced to 12-bit two's complement.
    function automatic logic [11:0] ref_val(input logic s, input logic [2:0] e, input logic [3:0] g);
        int m;
        int v;
        m = int'(g) * (1 << int'(e));
`ifdef FP_EXPAND_MIDPOINT_EN
        if (e != 3'd0) m = m + (((m >> (int'(e) - 1)) & 1) == 0 ? (1 << (int'(e) - 1)) : 0);
`endif
        v = s ? -m : m;
        return 12'(v);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // Present a code at a negedge while idle; returns at the negedge after acceptance.
    task automatic send(input logic s, input logic [2:0] e, input logic [3:0] g, input string tag);
        check({tag, "_in_ready_idle"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = e;
        in_sig   = g;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Wait for the result, optionally stall the consumer, and complete the transfer.
    task automatic collect(input logic [2:0] e, input logic [11:0] expv, input int hold,
                           input bit pend, input logic ps, input logic [2:0] pe,
                           input logic [3:0] pg, input string tag);
        int k;
        k = 1;
        while (out_valid !== 1'b1 && k < 20) begin
            check({tag, "_busy_shift"}, {31'd0, in_ready, busy}, 32'd1);
            in_valid  = 1'b1;
            in_sign   = 1'($urandom);
            in_exp    = 3'($urandom);
            in_sig    = 4'($urandom);
            out_ready = 1'($urandom);
            @(negedge clk);
            k++;
        end
        check({tag, "_latency"}, k, int'(e) + 2);
        in_valid = pend;
        if (pend) begin
            in_sign = ps;
            in_exp  = pe;
            in_sig  = pg;
        end
        out_ready = (hold == 0);
        check({tag, "_data"}, {20'd0, out_data}, {20'd0, expv});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid_ready"}, {30'd0, out_valid, in_ready}, 32'd2);
            check({tag, "_hold_data"}, {20'd0, out_data}, {20'd0, expv});
        end
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_done_valid_ready_busy"}, {29'd0, out_valid, in_ready, busy}, 32'd2);
    endtask

    logic [11:0] e_t2, e_t3a, e_t3b, e_t3c, e_t4a, e_t4b, e_t6;

    initial begin
        bit seen;
        logic       rs;
        logic [2:0] re;
        logic [3:0] rg;
        int         rh;

`ifdef FP_EXPAND_MIDPOINT_EN
        e_t2 = 12'h05C; e_t3a = 12'h840; e_t3b = 12'hFFB; e_t3c = 12'hFFE;
        e_t4a = 12'h011; e_t4b = 12'h00E; e_t6 = 12'h005;
`else
        e_t2 = 12'h058; e_t3a = 12'h880; e_t3b = 12'hFFB; e_t3c = 12'h000;
        e_t4a = 12'h010; e_t4b = 12'h00C; e_t6 = 12'h005;
`endif

        rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_sig = '0; out_ready = 1'b0;

        // Reset held for three cycles, in_ready low throughout.
        repeat (3) begin
            @(negedge clk);
            check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("idle_out_valid", {31'd0, out_valid}, 32'd0);
        check("idle_out_data", {20'd0, out_data}, 32'd0);
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Basic positive decode with immediate consumer.
        send(1'b0, 3'd3, 4'b1011, "t2");
        collect(3'd3, e_t2, 0, 1'b0, 1'b0, 3'd0, 4'd0, "t2");

        // Largest negative, exp=0 literal significand, negative zero.
        send(1'b1, 3'd7, 4'b1111, "t3a");
        collect(3'd7, e_t3a, 0, 1'b0, 1'b0, 3'd0, 4'd0, "t3a");
        send(1'b1, 3'd0, 4'b0101, "t3b");
        collect(3'd0, e_t3b, 1, 1'b0, 1'b0, 3'd0, 4'd0, "t3b");
        send(1'b1, 3'd2, 4'b0000, "t3c");
        collect(3'd2, e_t3c, 0, 1'b0, 1'b0, 3'd0, 4'd0, "t3c");

        // Backpressure with a second code waiting during HOLD.
        send(1'b0, 3'd1, 4'b1000, "t4a");
        collect(3'd1, e_t4a, 4, 1'b1, 1'b0, 3'd2, 4'b0011, "t4a");
        send(1'b0, 3'd2, 4'b0011, "t4b");
        collect(3'd2, e_t4b, 0, 1'b0, 1'b0, 3'd0, 4'd0, "t4b");

        // Positive exp=0 code is unaffected by midpoint reconstruction.
        send(1'b0, 3'd0, 4'b0101, "t6");
        collect(3'd0, e_t6, 0, 1'b0, 1'b0, 3'd0, 4'd0, "t6");

        // Reset in the middle of a shift abandons the code.
        send(1'b0, 3'd6, 4'b1010, "t5");
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5_rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t5_after_rst", {29'd0, busy, in_ready, out_valid}, 32'd2);
        check("t5_out_data", {20'd0, out_data}, 32'd0);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        check("t5_no_output", {31'd0, seen}, 32'd0);

        // Randomized codes and consumer stalls against the reference.
        repeat (40) begin
            rs = 1'($urandom);
            re = 3'($urandom);
            rg = 4'($urandom);
            rh = int'($urandom_range(0, 2));
            send(rs, re, rg, "rnd");
            collect(re, ref_val(rs, re, rg), rh, 1'b0, 1'b0, 3'd0, 4'd0, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
